// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU pipeline sequencer and its forwarding logic.
package ppu_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'b00,
        RUN      = 2'b01,
        MEM_WAIT = 2'b10
    } seq_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam int CTRL_W = 22;

    // r0 is hardwired to zero, so a write to it never produces a forwardable value.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/ppu_forward_unit.sv
// Operand-forwarding select for one source operand; purely combinational.
module ppu_forward_unit
    import ppu_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       ex_rf_enable,
    input  logic       ex_load_instr,
    input  logic       mem_rf_enable,
    input  logic       wb_rf_enable,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        // Load data does not exist yet in EX; that case is covered by the load-use stall.
        if (ex_rf_enable && !ex_load_instr && reg_match(src, ex_rd)) begin
            fwd_sel = FWD_EX;
        end else if (mem_rf_enable && reg_match(src, mem_rd)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_rf_enable && reg_match(src, wb_rd)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ppu_hazard_sequencer.sv
// Five-stage pipeline sequencer: boot drain, load-use stalls, branch squash,
// memory-wait freeze, operand forwarding and a saturating stall-cycle counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// BOOT     | draining NOP bubbles after reset, PC held
// RUN      | normal issue; load-use stall and branch squash decided here
// MEM_WAIT | data memory busy, whole pipe frozen
module ppu_hazard_sequencer
    import ppu_pkg::*;
#(
    parameter int BOOT_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             ex_rf_enable,
    input  logic             mem_rf_enable,
    input  logic             wb_rf_enable,
    input  logic             ex_load_instr,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             stall_cnt_clr,
    output logic             pc_ld,
    output logic             if_id_ld,
    output logic             if_id_flush,
    output logic             pipe_ld,
    output logic             id_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [3:0]       boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       load_use;
    logic       stall;
    logic       fwd_en;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    ppu_forward_unit u_fwd_a (
        .src           (id_rs),
        .ex_rd         (ex_rd),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .ex_rf_enable  (ex_rf_enable),
        .ex_load_instr (ex_load_instr),
        .mem_rf_enable (mem_rf_enable),
        .wb_rf_enable  (wb_rf_enable),
        .fwd_sel       (fwd_a_raw)
    );

    ppu_forward_unit u_fwd_b (
        .src           (id_rt),
        .ex_rd         (ex_rd),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .ex_rf_enable  (ex_rf_enable),
        .ex_load_instr (ex_load_instr),
        .mem_rf_enable (mem_rf_enable),
        .wb_rf_enable  (wb_rf_enable),
        .fwd_sel       (fwd_b_raw)
    );

    assign load_use = ex_load_instr && ex_rf_enable && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    always_comb begin
        pc_ld       = 1'b0;
        if_id_ld    = 1'b1;
        if_id_flush = 1'b1;
        pipe_ld     = 1'b1;
        id_bubble   = 1'b1;
        fwd_en      = 1'b0;
        stall       = 1'b0;
        state_d     = BOOT;
        boot_cnt_d  = BOOT_LOAD;

        case (state_q)
            BOOT: begin
                if (boot_cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    state_d    = BOOT;
                    boot_cnt_d = boot_cnt_q - 4'd1;
                end
            end
            RUN: begin
                fwd_en  = 1'b1;
                state_d = RUN;
                if (mem_busy) begin
                    pc_ld       = 1'b0;
                    if_id_ld    = 1'b0;
                    if_id_flush = 1'b0;
                    pipe_ld     = 1'b0;
                    id_bubble   = 1'b0;
                    stall       = 1'b1;
                    state_d     = MEM_WAIT;
                end else if (load_use) begin
                    pc_ld       = 1'b0;
                    if_id_ld    = 1'b0;
                    if_id_flush = 1'b0;
                    pipe_ld     = 1'b1;
                    id_bubble   = 1'b1;
                    stall       = 1'b1;
                end else if (ex_branch_taken) begin
                    // The delay slot sits in ID and proceeds; only the fetch behind it is squashed.
                    pc_ld       = 1'b1;
                    if_id_ld    = 1'b1;
                    if_id_flush = 1'b1;
                    pipe_ld     = 1'b1;
                    id_bubble   = 1'b0;
                end else begin
                    pc_ld       = 1'b1;
                    if_id_ld    = 1'b1;
                    if_id_flush = 1'b0;
                    pipe_ld     = 1'b1;
                    id_bubble   = 1'b0;
                end
            end
            MEM_WAIT: begin
                pc_ld       = 1'b0;
                if_id_ld    = 1'b0;
                if_id_flush = 1'b0;
                pipe_ld     = 1'b0;
                id_bubble   = 1'b0;
                fwd_en      = 1'b1;
                // The release cycle is still frozen, but only cycles with memory busy are tallied.
                stall       = mem_busy;
                state_d     = mem_busy ? MEM_WAIT : RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            boot_cnt_q  <= BOOT_LOAD;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a_sel = fwd_en ? fwd_a_raw : FWD_RF;
    assign fwd_b_sel = fwd_en ? fwd_b_raw : FWD_RF;
    assign seq_state = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule
